// File: rtl/armleocpu_csr_sequencer.sv
// Sequences one CSR instruction into CSR-unit accesses: a single read/write,
// or a read followed by a modify-write for set/clear forms, then a one-cycle response.
`ifndef ARMLEOCPU_CSR_CMD_WIDTH
`define ARMLEOCPU_CSR_CMD_WIDTH 4
`endif

module armleocpu_csr_sequencer (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [2:0]                          req_funct3,
    input  logic [11:0]                         req_csr_address,
    input  logic [4:0]                          req_rs1,
    input  logic [4:0]                          req_rd,
    input  logic [31:0]                         req_rs1_value,
    output logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] csr_cmd,
    output logic [11:0]                         csr_address,
    output logic [31:0]                         csr_writedata,
    input  logic [31:0]                         csr_readdata,
    input  logic                                csr_invalid,
    output logic                                done,
    output logic                                illegal,
    output logic                                rd_write,
    output logic [4:0]                          rd_index,
    output logic [31:0]                         rd_data
);

    localparam logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_NONE       = `ARMLEOCPU_CSR_CMD_WIDTH'(0);
    localparam logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_READ       = `ARMLEOCPU_CSR_CMD_WIDTH'(1);
    localparam logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_WRITE      = `ARMLEOCPU_CSR_CMD_WIDTH'(2);
    localparam logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] CMD_READ_WRITE = `ARMLEOCPU_CSR_CMD_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_MODIFY,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_funct3;
    logic [11:0] r_address;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rd;
    logic [31:0] r_rs1_value;
    logic [31:0] r_old;
    logic        r_illegal;
    logic [4:0]  r_rd_index;
    logic [31:0] r_rd_data;

    logic [31:0] w_operand;
    logic        w_is_rw;
    logic        w_is_set;
    logic        w_modify;
    logic        w_reads;

    assign w_operand = r_funct3[2] ? {27'b0, r_rs1} : r_rs1_value;
    assign w_is_rw   = (r_funct3[1:0] == 2'b01);
    assign w_is_set  = (r_funct3[1:0] == 2'b10);
    // Set/clear with rs1 (or uimm) zero is a pure read: no write-back phase.
    assign w_modify  = !w_is_rw && (r_rs1 != 5'd0);
    assign w_reads   = !(w_is_rw && (r_rd == 5'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        csr_cmd       = CMD_NONE;
        csr_writedata = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = (req_funct3[1:0] == 2'b00) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_is_rw) begin
                    csr_cmd       = (r_rd == 5'd0) ? CMD_WRITE : CMD_READ_WRITE;
                    csr_writedata = w_operand;
                end else begin
                    csr_cmd = CMD_READ;
                end
                w_next_state = (!csr_invalid && w_modify) ? S_MODIFY : S_RESP;
            end
            S_MODIFY: begin
                csr_cmd       = CMD_WRITE;
                csr_writedata = w_is_set ? (r_old | w_operand) : (r_old & ~w_operand);
                w_next_state  = S_RESP;
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3    <= '0;
            r_address   <= '0;
            r_rs1       <= '0;
            r_rd        <= '0;
            r_rs1_value <= '0;
            r_old       <= '0;
            r_illegal   <= 1'b0;
            r_rd_index  <= '0;
            r_rd_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3    <= req_funct3;
                        r_address   <= req_csr_address;
                        r_rs1       <= req_rs1;
                        r_rd        <= req_rd;
                        r_rs1_value <= req_rs1_value;
                        r_old       <= '0;
                        r_illegal   <= (req_funct3[1:0] == 2'b00);
                        if (req_funct3[1:0] == 2'b00) begin
                            r_rd_index <= req_rd;
                            r_rd_data  <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_old <= csr_readdata;
                    if (csr_invalid) begin
                        r_illegal <= 1'b1;
                    end
                    // Response registers load on the edge that enters RESP so they hold afterwards.
                    if (w_next_state == S_RESP) begin
                        r_rd_index <= r_rd;
                        r_rd_data  <= w_reads ? csr_readdata : '0;
                    end
                end
                S_MODIFY: begin
                    if (csr_invalid) begin
                        r_illegal <= 1'b1;
                    end
                    r_rd_index <= r_rd;
                    r_rd_data  <= r_old;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign csr_address = r_address;
    assign done        = (r_state == S_RESP);
    assign illegal     = done && r_illegal;
    assign rd_write    = done && !r_illegal && (r_rd != 5'd0);
    assign rd_index    = r_rd_index;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_armleocpu_csr_sequencer.sv
// Randomized scoreboard bench: a reference model predicts CSR commands and responses,
// independent monitors compare them as the sequencer produces them.
`ifndef ARMLEOCPU_CSR_CMD_WIDTH
`define ARMLEOCPU_CSR_CMD_WIDTH 4
`endif

module tb_armleocpu_csr_sequencer;

    localparam int CW = `ARMLEOCPU_CSR_CMD_WIDTH;
    localparam logic [CW-1:0] C_NONE = CW'(0);
    localparam logic [CW-1:0] C_READ = CW'(1);
    localparam logic [CW-1:0] C_WRITE = CW'(2);
    localparam logic [CW-1:0] C_RW = CW'(3);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_funct3 = '0;
    logic [11:0]   req_csr_address = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rd = '0;
    logic [31:0]   req_rs1_value = '0;
    logic [CW-1:0] csr_cmd;
    logic [11:0]   csr_address;
    logic [31:0]   csr_writedata;
    logic [31:0]   csr_readdata;
    logic          csr_invalid;
    logic          done;
    logic          illegal;
    logic          rd_write;
    logic [4:0]    rd_index;
    logic [31:0]   rd_data;

    armleocpu_csr_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_csr_address(req_csr_address),
        .req_rs1(req_rs1), .req_rd(req_rd), .req_rs1_value(req_rs1_value),
        .csr_cmd(csr_cmd), .csr_address(csr_address), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata), .csr_invalid(csr_invalid),
        .done(done), .illegal(illegal), .rd_write(rd_write),
        .rd_index(rd_index), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // CSR unit: 0x340/0x341 read-write, 0xFC0 read-only (value 3), everything else absent.
    logic [31:0] hw_340 = '0;
    logic [31:0] hw_341 = '0;
    always_comb begin
        csr_readdata = '0;
        csr_invalid  = 1'b0;
        case (csr_address)
            12'h340: csr_readdata = hw_340;
            12'h341: csr_readdata = hw_341;
            12'hFC0: begin
                csr_readdata = 32'd3;
                csr_invalid  = (csr_cmd == C_WRITE) || (csr_cmd == C_RW);
            end
            default: csr_invalid = (csr_cmd != C_NONE);
        endcase
    end
    always @(posedge clk) begin
        if ((csr_cmd == C_WRITE || csr_cmd == C_RW) && !csr_invalid) begin
            if (csr_address == 12'h340) hw_340 <= csr_writedata;
            if (csr_address == 12'h341) hw_341 <= csr_writedata;
        end
    end

    typedef struct {
        logic        illegal;
        logic        rd_write;
        logic [4:0]  rd_index;
        logic [31:0] rd_data;
        int          lat;
        int          acc;
    } resp_t;
    typedef struct {
        logic [CW-1:0] cmd;
        logic [11:0]   addr;
        logic [31:0]   wdata;
    } cmd_t;

    resp_t resp_q[$];
    cmd_t  cmd_q[$];

    logic [31:0] ref_340 = '0;
    logic [31:0] ref_341 = '0;

    function automatic logic known(input logic [11:0] a);
        return (a == 12'h340) || (a == 12'h341) || (a == 12'hFC0);
    endfunction
    function automatic logic [31:0] ref_get(input logic [11:0] a);
        if (a == 12'h340) return ref_340;
        if (a == 12'h341) return ref_341;
        if (a == 12'hFC0) return 32'd3;
        return '0;
    endfunction
    task automatic ref_set(input logic [11:0] a, input logic [31:0] v);
        if (a == 12'h340) ref_340 = v;
        if (a == 12'h341) ref_341 = v;
    endtask

    // Predicts commands and the response of one instruction from the architectural rules.
    task automatic predict(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                           input logic [4:0] rd, input logic [31:0] val, input int acc);
        resp_t e;
        logic [31:0] op;
        logic [31:0] old;
        logic [31:0] nv;
        logic inv;
        op = f3[2] ? {27'b0, rs1} : val;
        inv = 1'b0;
        e.rd_index = rd;
        e.rd_data = '0;
        e.acc = acc;
        e.lat = 2;
        if (f3[1:0] == 2'b00) begin
            inv = 1'b1;
            e.lat = 1;
        end else if (f3[1:0] == 2'b01) begin
            cmd_q.push_back('{cmd: (rd == 0) ? C_WRITE : C_RW, addr: a, wdata: op});
            inv = !known(a) || (a == 12'hFC0);
            if (!inv) begin
                old = ref_get(a);
                ref_set(a, op);
                e.rd_data = (rd != 0) ? old : 32'd0;
            end
        end else begin
            cmd_q.push_back('{cmd: C_READ, addr: a, wdata: '0});
            if (!known(a)) begin
                inv = 1'b1;
            end else begin
                old = ref_get(a);
                e.rd_data = old;
                if (rs1 != 0) begin
                    nv = (f3[1:0] == 2'b10) ? (old | op) : (old & ~op);
                    cmd_q.push_back('{cmd: C_WRITE, addr: a, wdata: nv});
                    e.lat = 3;
                    if (a == 12'hFC0) inv = 1'b1;
                    else ref_set(a, nv);
                end
            end
        end
        e.illegal = inv;
        e.rd_write = !inv && (rd != 0);
        resp_q.push_back(e);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("illegal", 32'(illegal), 32'(e.illegal));
                chk("rd_write", 32'(rd_write), 32'(e.rd_write));
                chk("rd_index", 32'(rd_index), 32'(e.rd_index));
                if (!e.illegal) chk("rd_data", rd_data, e.rd_data);
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end else if (!done) begin
            chk("idle_flags", {30'b0, illegal, rd_write}, 32'd0);
        end
    end

    // Command monitor.
    always @(negedge clk) begin
        if (csr_cmd != C_NONE) begin
            if (cmd_q.size() == 0) begin
                chk("unexpected_cmd", 32'(csr_cmd), 32'(C_NONE));
            end else begin
                cmd_t c;
                c = cmd_q.pop_front();
                chk("csr_cmd", 32'(csr_cmd), 32'(c.cmd));
                chk("csr_address", 32'(csr_address), 32'(c.addr));
                if (c.cmd != C_READ) chk("csr_writedata", csr_writedata, c.wdata);
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at a negedge. Optionally holds junk valid while busy.
    task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                          input logic [4:0] rd, input logic [31:0] val, input logic junk);
        int t;
        wait_ready();
        req_funct3 = f3;
        req_csr_address = a;
        req_rs1 = rs1;
        req_rd = rd;
        req_rs1_value = val;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        predict(f3, a, rs1, rd, val, cyc);
        if (junk) begin
            req_funct3 = 3'($urandom);
            req_csr_address = 12'h340;
            req_rs1 = 5'($urandom);
            req_rd = 5'($urandom);
            req_rs1_value = $urandom;
            @(negedge clk);
            t = 0;
            while (!req_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            req_valid = 1'b0;
        end else begin
            req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((resp_q.size() != 0 || !req_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_resp_q", 32'(resp_q.size()), 32'd0);
    endtask

    initial begin
        logic [11:0] addrs [4];
        addrs[0] = 12'h340; addrs[1] = 12'h341; addrs[2] = 12'hFC0; addrs[3] = 12'h7FF;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_cmd", 32'(csr_cmd), 32'(C_NONE));
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_index", 32'(rd_index), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(3'b001, 12'h340, 5'd1, 5'd5, 32'h12345678, 1'b0);
        do_req(3'b001, 12'h340, 5'd1, 5'd0, 32'h0000000F, 1'b0);
        do_req(3'b010, 12'h340, 5'd3, 5'd9, 32'h000000F0, 1'b0);
        do_req(3'b111, 12'h340, 5'd3, 5'd0, 32'h0, 1'b0);
        do_req(3'b010, 12'hFC0, 5'd0, 5'd7, 32'h0, 1'b0);
        do_req(3'b001, 12'hFC0, 5'd2, 5'd4, 32'hDEAD, 1'b0);
        do_req(3'b100, 12'h340, 5'd2, 5'd4, 32'hBEEF, 1'b1);
        drain();
        chk("mscratch_after_directed", hw_340, 32'h000000FC);

        // Reset while the write-back phase is on the bus.
        do_req(3'b010, 12'h340, 5'd3, 5'd6, 32'h000000F0, 1'b0);
        void'(resp_q.pop_back());
        ref_340 = 32'h000000FC;
        @(negedge clk);
        #2;
        chk("pre_reset_cmd_seen", 32'(cmd_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("reset_cmd_none", 32'(csr_cmd), 32'(C_NONE));
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("reset_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mscratch_after_reset", hw_340, 32'h000000FC);
        do_req(3'b001, 12'h340, 5'd0, 5'd8, 32'hA5A5A5A5, 1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [4:0] rs1;
            logic [4:0] rd;
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_req(3'($urandom), addrs[$urandom_range(0, 3)], rs1, rd, $urandom,
                   1'($urandom_range(0, 1)));
        end
        drain();
        chk("final_cmd_q", 32'(cmd_q.size()), 32'd0);
        chk("final_mscratch", hw_340, ref_340);
        chk("final_mscratch2", hw_341, ref_341);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
